cpu_ram: RTL and testbench

CPU_RAM -- requirements
Module: cpu_ram

---
 rtl/cpu_ram.sv | 75 +++++++
 tb/tb_cpu_ram.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cpu_ram.sv
// cpu_ram: accumulator CPU core sharing a single-port synchronous RAM, with a memory-mapped I/O write port
module cpu_ram #(
  parameter int A = 12,
  parameter int D = 8,
  parameter INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  output logic       io_we,
  output logic [4:0] io_addr,
  output logic [7:0] io_wdata,
  output logic [5:0] dbg_pc,
  output logic [7:0] dbg_acc
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, LOAD} state_t;
  state_t state, state_n;
  logic [5:0] pc, pc_n, addr;
  logic [7:0] acc, acc_n, ir, ir_n, dout, din, rdata;
  logic rw, io_rd, sel;
  logic [D-1:0] mem [2**A];
  initial for (int i = 0; i < 2**A; i++) mem[i] = '0;
  assign sel = ~addr[5];
  assign din = io_rd ? 8'h00 : rdata;
  assign io_we = ~rw & addr[5];
  assign io_addr = addr[4:0];
  assign io_wdata = dout;
  assign dbg_pc = pc;
  assign dbg_acc = acc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    acc_n = acc;
    ir_n = ir;
    addr = pc;
    rw = 1'b1;
    dout = acc;
    case (state)
      FETCH: state_n = DECODE;
      DECODE: begin
        ir_n = din;
        pc_n = pc + 6'd1;
        state_n = EXEC;
      end
      EXEC: begin
        addr = ir[5:0];
        rw = ir[7:6] != 2'b10;
        pc_n = ir[7:6] == 2'b11 ? ir[5:0] : pc;
        state_n = ir[7] ? FETCH : LOAD;
      end
      default: begin
        acc_n = ir[6] ? acc + din : din;
        state_n = FETCH;
      end
    endcase
    if (reset) rw = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      acc <= '0;
      ir <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      acc <= acc_n;
      ir <= ir_n;
    end
  end
  always_ff @(posedge clk) begin
    if (sel & ~rw) mem[A'(addr)] <= dout;
    if (sel & rw) rdata <= mem[A'(addr)];
    io_rd <= addr[5];
  end
endmodule

// File: tb/tb_cpu_ram.sv
// tb_cpu_ram: randomized and directed programs checked against an instruction-level model via an I/O scoreboard
module tb_cpu_ram;
  logic clk = 0, reset = 1;
  logic io_we;
  logic [4:0] io_addr;
  logic [7:0] io_wdata, dbg_acc;
  logic [5:0] dbg_pc;
  typedef struct {int cyc; int a; int d;} ev_t;
  ev_t exp_q[$];
  ev_t e;
  logic [7:0] prog [32];
  logic [7:0] mm [32];
  int cyc = 0, checks = 0, fails = 0, m_t, m_pc, m_acc;

  cpu_ram dut (
    .clk(clk), .reset(reset), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .dbg_pc(dbg_pc), .dbg_acc(dbg_acc)
  );

  always #5 clk = ~clk;
  // cycle 0 is the first cycle after the last reset edge
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: every I/O write strobe must match the next expected event
  always @(negedge clk) if (io_we === 1'b1) begin
    if (exp_q.size() == 0) chk("unexpected_io_we", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("io_cycle", cyc, e.cyc);
      chk("io_addr", int'(io_addr), e.a);
      chk("io_wdata", int'(io_wdata), e.d);
    end
  end

  function automatic int rd(input int a);
    return a < 32 ? int'(mm[a]) : 0;
  endfunction

  // instruction-level reference: runs whole instructions until the cycle budget is reached
  task automatic model(input int budget);
    int t = 0, pc = 0, acc = 0, ins, op;
    for (int i = 0; i < 32; i++) mm[i] = prog[i];
    while (t < budget) begin
      ins = rd(pc);
      op = ins % 64;
      pc = (pc + 1) % 64;
      case (ins / 64)
        0: begin acc = rd(op); t += 4; end
        1: begin acc = (acc + rd(op)) % 256; t += 4; end
        2: begin
          if (op >= 32) exp_q.push_back('{t + 2, op - 32, acc});
          else mm[op] = 8'(acc);
          t += 3;
        end
        default: begin pc = op; t += 3; end
      endcase
    end
    m_t = t; m_pc = pc; m_acc = acc;
  endtask

  task automatic load_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 32; i++) dut.mem[i] = prog[i];
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic run(input int budget);
    load_reset();
    chk("reset_pc", int'(dbg_pc), 0);
    chk("reset_acc", int'(dbg_acc), 0);
    chk("reset_io_we", int'(io_we), 0);
    model(budget);
    reset = 0;
    while (cyc < m_t) @(negedge clk);
    chk("final_pc", int'(dbg_pc), m_pc);
    chk("final_acc", int'(dbg_acc), m_acc);
    for (int i = 0; i < 32; i++) chk($sformatf("ram[%0h]", i), int'(dut.mem[i]), int'(mm[i]));
    chk("events_left", exp_q.size(), 0);
  endtask

  task automatic clr();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  // reset asserted during the EXEC cycle of a store must suppress it
  task automatic abort(input logic [7:0] sta);
    clr();
    prog[0] = 8'h10; prog[1] = sta; prog[16] = 8'h33;
    load_reset();
    reset = 0;
    while (cyc < 5) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("abort_io_we", int'(io_we), 0);
    @(negedge clk);
    chk("abort_pc", int'(dbg_pc), 0);
    chk("abort_acc", int'(dbg_acc), 0);
    chk("abort_ram11", int'(dut.mem[17]), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clr();
    prog[0] = 8'h10; prog[1] = 8'h51; prog[2] = 8'hA0; prog[3] = 8'hC3; prog[16] = 8'h05; prog[17] = 8'h03;
    run(60);
    prog[16] = 8'hFF; prog[17] = 8'h02;
    run(60);
    clr();
    prog[0] = 8'h10; prog[1] = 8'h9F; prog[2] = 8'h1F; prog[3] = 8'hA1; prog[4] = 8'hC4; prog[16] = 8'h5A;
    run(60);
    clr();
    prog[0] = 8'h10; prog[1] = 8'h25; prog[2] = 8'hA0; prog[3] = 8'hC3; prog[16] = 8'h77;
    run(60);
    clr();
    prog[0] = 8'hA0; prog[1] = 8'h51; prog[2] = 8'hFE; prog[17] = 8'h01;
    run(80);
    abort(8'hA0);
    abort(8'h91);
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      run(300);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
